sgm_vertical_path_agg: RTL
==========================

Name: sgm_vertical_path_agg

Overview:
- Streaming SGM cost aggregation along the vertical (top-to-bottom) path, MAX_SAMPLES_PER_CLOCK pixels per clock.
- Consumes per-pixel matching cost vectors plus the previous row's aggregated vectors, which a line-length BRAM delay line returns.
- Produces the current row's aggregated vectors, which feed both that delay line's din and the downstream direction-summing stage.
- Lanes are independent: the vertical path only references the same column in the row above.

Parameters:
- DISPARITIES, 16, disparity levels per pixel (D).
- COST_WIDTH, 8, bits per matching cost entry.
- MAX_SAMPLES_PER_CLOCK, 4, pixel lanes per beat (ppc).
- P1, 10, small smoothness penalty (|Δd|=1).
- P2, 60, large smoothness penalty (|Δd|>1); must satisfy P2 >= P1.
- AGG_WIDTH, $clog2((1<<COST_WIDTH)+P2), bits per aggregated entry.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  beat enable; pipeline advances only when 1.
- tuser  in  1  start of frame, marks the first beat of row 0.
- tlast  in  1  end of row.
- cost_in  in  MAX_SAMPLES_PER_CLOCK*DISPARITIES*COST_WIDTH  matching costs; lane-major, d=0 in LSBs of each lane.
- prev_in  in  MAX_SAMPLES_PER_CLOCK*DISPARITIES*AGG_WIDTH  aggregated vectors of the previous row, same column, from the delay line.
- agg_out  out  MAX_SAMPLES_PER_CLOCK*DISPARITIES*AGG_WIDTH  aggregated vectors L(p,d).
- valid_out  out  1  agg_out holds a new beat.
- tlast_out  out  1  tlast delayed to align with agg_out.
- first_row_out  out  1  beat belongs to row 0.

Behaviour:
- Per lane and disparity: L(p,d) = C(p,d) + min(Lp(d), Lp(d-1)+P1, Lp(d+1)+P1, minLp+P2) - minLp.
  - Lp = prev_in; minLp = min over d of Lp.
  - Out-of-range neighbours (d-1<0, d+1>=D) are excluded from the min.
- Row 0 (tuser through the first tlast): Lp is forced to 0, so L = C zero-extended. prev_in is ignored.
- Row tracking:
  - first_row flag is set on ce&&tuser.
  - It is cleared on the beat after ce&&tlast while set.
  - If tuser and tlast coincide (single-beat row), the flag still applies to that beat only.
- Pipeline, each stage enabled by ce:
  - S1: register cost_in, prev_in and minLp (comparator tree over D entries).
  - S2: register per-d candidate minimum and C.
  - S3: register L.
- Latency is 3 ce-qualified beats from input to agg_out. The delay line's READ_POS_SHIFT must compensate; this is documented at integration.
- When ce=0, all registers and outputs hold; valid_out=0 that cycle.
- valid_out = ce && (S3 holds data).
- Fill: after reset, valid_out stays 0 until three ce beats have entered.
- Arithmetic:
  - Candidate sums are computed at AGG_WIDTH+1 bits.
  - min - minLp is non-negative by construction, bounded by P2.
  - The final add saturates at 2^AGG_WIDTH-1 (unreachable with the default width; kept for overridden parameters).
- tlast_out and first_row_out travel in the same 3-stage shift as data.
- Reset (asynchronous, any time, including mid-row):
  - agg_out=0, valid_out=0, tlast_out=0, first_row_out=0.
  - Fill counter=0, first_row flag=0.
  - After release, output resumes only after a fresh tuser beat.
  - Beats before tuser are processed as a non-first row.

Optional Feature:
- Macro SGM_VERT_MIN_OUT_EN.
- Defined:
  - Extra output min_out [MAX_SAMPLES_PER_CLOCK*AGG_WIDTH] = per-lane min over d of agg_out.
  - Registered in a 4th stage, aligned with a 1-beat-delayed copy of valid_out/tlast_out exported as min_valid_out/min_tlast_out.
  - Lets the next row reuse it as minLp without recomputing.
  - Reset value 0.
- Undefined: port and stage absent; core behaviour and latency unchanged.

Test Plan:
- Row 0 pass-through: D=4, ppc=1, tuser=1, cost_in={5,5,5,5}, prev_in={99,...} -> after 3 beats agg_out={5,5,5,5}, first_row_out=1.
- Penalty selection: row 1, C={5,5,5,5}, prev={0,20,40,80}, P1=10, P2=60 -> agg_out={5,15,35,55}.
- Min normalisation: prev={100,100,100,100}, C={1,2,3,4} -> agg_out={1,2,3,4}.
- Stall: hold ce=0 for 5 cycles mid-row -> agg_out constant, valid_out=0. On resume, outputs continue in order with no dropped or duplicated beat.
- Row/frame boundary: 8-beat rows, tlast on beat 7 -> first_row_out high on beats 0-7 only. tlast_out aligns with beat 7 of each row.
- Async reset mid-row: drop rst for half a cycle -> all outputs 0 immediately. No valid_out until 3 beats after the next tuser-qualified input.

Source files
------------

// File: rtl/sgm_vertical_path_agg.sv
// Top-to-bottom SGM path aggregation, MAX_SAMPLES_PER_CLOCK independent pixel lanes.
// Three ce-qualified stages: S1 (input + minLp), S2 (penalised minimum), S3 (add + saturate).
// Optional macro SGM_VERT_MIN_OUT_EN adds a 4th stage exporting the per-lane minimum of agg_out.
module sgm_vertical_path_agg #(
    parameter int unsigned DISPARITIES           = 16,
    parameter int unsigned COST_WIDTH            = 8,
    parameter int unsigned MAX_SAMPLES_PER_CLOCK = 4,
    parameter int unsigned P1                    = 10,
    parameter int unsigned P2                    = 60,
    parameter int unsigned AGG_WIDTH             = $clog2((1 << COST_WIDTH) + P2)
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic                                                    ce,
    input  logic                                                    tuser,
    input  logic                                                    tlast,
    input  logic [MAX_SAMPLES_PER_CLOCK*DISPARITIES*COST_WIDTH-1:0] cost_in,
    input  logic [MAX_SAMPLES_PER_CLOCK*DISPARITIES*AGG_WIDTH-1:0]  prev_in,
    output logic [MAX_SAMPLES_PER_CLOCK*DISPARITIES*AGG_WIDTH-1:0]  agg_out,
    output logic                                                    valid_out,
    output logic                                                    tlast_out,
    output logic                                                    first_row_out
`ifdef SGM_VERT_MIN_OUT_EN
    ,
    output logic [MAX_SAMPLES_PER_CLOCK*AGG_WIDTH-1:0]              min_out,
    output logic                                                    min_valid_out,
    output logic                                                    min_tlast_out
`endif
);

    localparam int unsigned D   = DISPARITIES;
    localparam int unsigned PPC = MAX_SAMPLES_PER_CLOCK;
    localparam int unsigned CW  = COST_WIDTH;
    localparam int unsigned AW  = AGG_WIDTH;
    localparam int unsigned SW  = AGG_WIDTH + 1;

    logic          first_row_q;
    logic          first_c;
    logic          start_c;
    logic [1:0]    fill_q;

    logic [CW-1:0] cost_c   [PPC][D];
    logic [AW-1:0] prev_c   [PPC][D];
    logic [AW-1:0] min_c    [PPC];

    logic [CW-1:0] s1_cost  [PPC][D];
    logic [AW-1:0] s1_prev  [PPC][D];
    logic [AW-1:0] s1_min   [PPC];
    logic          s1_tlast;
    logic          s1_first;

    logic [AW-1:0] cand_c   [PPC][D];
    logic [CW-1:0] s2_cost  [PPC][D];
    logic [AW-1:0] s2_cand  [PPC][D];
    logic          s2_tlast;
    logic          s2_first;

    logic [AW-1:0] l_c      [PPC][D];
    logic [AW-1:0] s3_l     [PPC][D];
    logic          s3_tlast;
    logic          s3_first;

    // A beat is row 0 if it opens the frame or the row-0 flag is still set
    assign first_c = tuser | first_row_q;

    // Output is only produced for beats at or after the first tuser since reset
    assign start_c = tuser | (fill_q != 2'd0);

    // Row-0 flag: set by tuser, dropped after the beat carrying tlast
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_row_q <= 1'b0;
        end else if (ce) begin
            first_row_q <= first_c & ~tlast;
        end
    end

    // Fill counter: counts tuser-qualified beats entering the pipe, saturates at depth
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_q <= 2'd0;
        end else if (ce && start_c && (fill_q != 2'd3)) begin
            fill_q <= fill_q + 2'd1;
        end
    end

    // Unpack lane-major input buses; row 0 sees an all-zero previous row
    always_comb begin
        for (int unsigned l = 0; l < PPC; l++) begin
            for (int unsigned d = 0; d < D; d++) begin
                cost_c[l][d] = cost_in[(l*D+d)*CW +: CW];
                prev_c[l][d] = first_c ? '0 : prev_in[(l*D+d)*AW +: AW];
            end
        end
    end

    // minLp: minimum over disparities of the previous-row vector, per lane
    always_comb begin
        logic [AW-1:0] m;
        m = '0;
        for (int unsigned l = 0; l < PPC; l++) begin
            m = prev_c[l][0];
            for (int unsigned d = 1; d < D; d++) begin
                if (prev_c[l][d] < m) begin
                    m = prev_c[l][d];
                end
            end
            min_c[l] = m;
        end
    end

    // S1: register costs, previous-row vectors and minLp
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned l = 0; l < PPC; l++) begin
                for (int unsigned d = 0; d < D; d++) begin
                    s1_cost[l][d] <= '0;
                    s1_prev[l][d] <= '0;
                end
                s1_min[l] <= '0;
            end
            s1_tlast <= 1'b0;
            s1_first <= 1'b0;
        end else if (ce) begin
            for (int unsigned l = 0; l < PPC; l++) begin
                for (int unsigned d = 0; d < D; d++) begin
                    s1_cost[l][d] <= cost_c[l][d];
                    s1_prev[l][d] <= prev_c[l][d];
                end
                s1_min[l] <= min_c[l];
            end
            s1_tlast <= tlast;
            s1_first <= first_c;
        end
    end

    // Penalised minimum minus minLp; out-of-range neighbours are skipped
    always_comb begin
        logic [SW-1:0] best;
        logic [SW-1:0] t;
        int unsigned   dm;
        int unsigned   dp;
        best = '0;
        t    = '0;
        dm   = 0;
        dp   = 0;
        for (int unsigned l = 0; l < PPC; l++) begin
            for (int unsigned d = 0; d < D; d++) begin
                dm   = (d == 0) ? 0 : d - 1;
                dp   = (d == D - 1) ? d : d + 1;
                best = SW'(s1_prev[l][d]);
                if (d != 0) begin
                    t = SW'(s1_prev[l][dm]) + SW'(P1);
                    if (t < best) best = t;
                end
                if (d != D - 1) begin
                    t = SW'(s1_prev[l][dp]) + SW'(P1);
                    if (t < best) best = t;
                end
                t = SW'(s1_min[l]) + SW'(P2);
                if (t < best) best = t;
                cand_c[l][d] = AW'(best - SW'(s1_min[l]));
            end
        end
    end

    // S2: register the normalised candidate and the matching cost
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned l = 0; l < PPC; l++) begin
                for (int unsigned d = 0; d < D; d++) begin
                    s2_cost[l][d] <= '0;
                    s2_cand[l][d] <= '0;
                end
            end
            s2_tlast <= 1'b0;
            s2_first <= 1'b0;
        end else if (ce) begin
            for (int unsigned l = 0; l < PPC; l++) begin
                for (int unsigned d = 0; d < D; d++) begin
                    s2_cost[l][d] <= s1_cost[l][d];
                    s2_cand[l][d] <= cand_c[l][d];
                end
            end
            s2_tlast <= s1_tlast;
            s2_first <= s1_first;
        end
    end

    // L = C + candidate, saturating at the aggregate width
    always_comb begin
        logic [SW-1:0] sum;
        sum = '0;
        for (int unsigned l = 0; l < PPC; l++) begin
            for (int unsigned d = 0; d < D; d++) begin
                sum         = SW'(s2_cost[l][d]) + SW'(s2_cand[l][d]);
                l_c[l][d]   = sum[AW] ? '1 : sum[AW-1:0];
            end
        end
    end

    // S3: register the aggregated vectors and sideband
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned l = 0; l < PPC; l++) begin
                for (int unsigned d = 0; d < D; d++) begin
                    s3_l[l][d] <= '0;
                end
            end
            s3_tlast <= 1'b0;
            s3_first <= 1'b0;
        end else if (ce) begin
            for (int unsigned l = 0; l < PPC; l++) begin
                for (int unsigned d = 0; d < D; d++) begin
                    s3_l[l][d] <= l_c[l][d];
                end
            end
            s3_tlast <= s2_tlast;
            s3_first <= s2_first;
        end
    end

    // Pack S3 onto the lane-major output bus
    always_comb begin
        agg_out = '0;
        for (int unsigned l = 0; l < PPC; l++) begin
            for (int unsigned d = 0; d < D; d++) begin
                agg_out[(l*D+d)*AW +: AW] = s3_l[l][d];
            end
        end
    end

    assign valid_out     = ce & (fill_q == 2'd3);
    assign tlast_out     = s3_tlast;
    assign first_row_out = s3_first;

`ifdef SGM_VERT_MIN_OUT_EN
    logic [AW-1:0] lmin_c [PPC];
    logic [AW-1:0] s4_min [PPC];
    logic          s4_valid;
    logic          s4_tlast;

    // Per-lane minimum of the S3 vector, reusable as next row's minLp
    always_comb begin
        logic [AW-1:0] m;
        m = '0;
        for (int unsigned l = 0; l < PPC; l++) begin
            m = s3_l[l][0];
            for (int unsigned d = 1; d < D; d++) begin
                if (s3_l[l][d] < m) begin
                    m = s3_l[l][d];
                end
            end
            lmin_c[l] = m;
        end
    end

    // S4: minimum plus a one-beat-delayed copy of valid/tlast
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned l = 0; l < PPC; l++) begin
                s4_min[l] <= '0;
            end
            s4_valid <= 1'b0;
            s4_tlast <= 1'b0;
        end else if (ce) begin
            for (int unsigned l = 0; l < PPC; l++) begin
                s4_min[l] <= lmin_c[l];
            end
            s4_valid <= (fill_q == 2'd3);
            s4_tlast <= s3_tlast;
        end
    end

    // Pack per-lane minima
    always_comb begin
        min_out = '0;
        for (int unsigned l = 0; l < PPC; l++) begin
            min_out[l*AW +: AW] = s4_min[l];
        end
    end

    assign min_valid_out = ce & s4_valid;
    assign min_tlast_out = s4_tlast;
`endif

endmodule
